// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------------------
// Module  : rv32i_pkg
// Brief   : RV32I load/store funct3 encodings, LSU state type and legality helpers
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Unsigned variants exist only for loads.
    function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
        case (funct3)
            FUNCT3_B, FUNCT3_H, FUNCT3_W: funct3_illegal = 1'b0;
            FUNCT3_BU, FUNCT3_HU:         funct3_illegal = write;
            default:                      funct3_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            FUNCT3_H, FUNCT3_HU: addr_misaligned = addr_lo[0];
            FUNCT3_W:            addr_misaligned = (addr_lo != 2'b00);
            default:             addr_misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//------------------------------------------------------------------------------
// Module  : lsu_align
// Brief   : Store byte-lane/strobe generation and load extract/sign-extension
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [31:0] o_lane_wdata,
    output logic [3:0]  o_lane_wstrb,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_load_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

    always_comb begin
        o_lane_wdata = i_store_data;
        o_lane_wstrb = 4'b0000;
        o_load_data  = i_load_word;
        case (i_funct3)
            FUNCT3_B: begin
                o_lane_wdata = {4{i_store_data[7:0]}};
                o_lane_wstrb = 4'b0001 << i_addr_lo;
                o_load_data  = {{24{w_byte[7]}}, w_byte};
            end
            FUNCT3_H: begin
                o_lane_wdata = {2{i_store_data[15:0]}};
                o_lane_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_load_data  = {{16{w_half[15]}}, w_half};
            end
            FUNCT3_W: begin
                o_lane_wstrb = 4'b1111;
            end
            FUNCT3_BU: o_load_data = {24'h0, w_byte};
            FUNCT3_HU: o_load_data = {16'h0, w_half};
            default:   o_load_data = 32'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module  : load_store_unit
// Brief   : RV32I LSU: request capture, word-aligned memory access with ack timeout
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    lsu_state_t       r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [2:0]       r_funct3;
    logic             r_write;
    logic             r_fault;
    logic             r_misaligned;
    logic [CNT_W-1:0] r_cnt;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic [31:0] w_lane_wdata;
    logic [3:0]  w_lane_wstrb;
    logic [31:0] w_load_data;

    // Legality is judged on exactly the values being captured this edge.
    assign w_accept     = req_valid & req_ready;
    assign w_illegal    = funct3_illegal(req_write, req_funct3);
    assign w_misaligned = addr_misaligned(req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_store_data (r_wdata),
        .i_load_word  (r_rdata),
        .o_lane_wdata (w_lane_wdata),
        .o_lane_wstrb (w_lane_wstrb),
        .o_load_data  (w_load_data)
    );

    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = w_lane_wdata;
    assign mem_wstrb = mem_write ? w_lane_wstrb : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rdata        <= '0;
            r_funct3       <= '0;
            r_write        <= 1'b0;
            r_fault        <= 1'b0;
            r_misaligned   <= 1'b0;
            r_cnt          <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            rsp_fault      <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    rsp_rdata      <= '0;
                    rsp_misaligned <= 1'b0;
                    rsp_fault      <= 1'b0;
                    r_cnt          <= '0;
                    if (w_accept) begin
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_funct3     <= req_funct3;
                        r_write      <= req_write;
                        r_rdata      <= '0;
                        r_fault      <= w_illegal;
                        r_misaligned <= ~w_illegal & w_misaligned;
                        req_ready    <= 1'b0;
                        if (w_illegal || w_misaligned) begin
                            r_state <= RESP;
                        end else begin
                            r_state   <= ACCESS;
                            mem_read  <= ~req_write;
                            mem_write <= req_write;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    // An ack arriving on the final wait cycle wins over the timeout.
                    if (mem_ack) begin
                        r_rdata   <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        r_state   <= RESP;
                    end else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        r_fault   <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid      <= 1'b1;
                    rsp_misaligned <= r_misaligned;
                    rsp_fault      <= r_fault;
                    rsp_rdata      <= (r_write || r_fault || r_misaligned) ? 32'h0 : w_load_data;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_load_store_unit
// Brief   : Scoreboard bench for load_store_unit
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    load_store_unit #(.MAX_WAIT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int rsp_cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc++;

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h mis=%b fault=%b with nothing pending",
                         rsp_rdata, rsp_misaligned, rsp_fault);
            end else begin
                got = sb.pop_front();
                if ({rsp_rdata, rsp_misaligned, rsp_fault} !== {got.rdata, got.mis, got.fault}) begin
                    errors++;
                    $display("FAIL rsp_payload: got rdata=%h mis=%b fault=%b, want rdata=%h mis=%b fault=%b",
                             rsp_rdata, rsp_misaligned, rsp_fault, got.rdata, got.mis, got.fault);
                end
            end
        end
    end

    // Stimulus tables
    logic [2:0]  st_f3   [4] = '{FUNCT3_H, FUNCT3_H, FUNCT3_B, FUNCT3_B};
    logic [31:0] st_addr [4] = '{32'h22, 32'h20, 32'h21, 32'h13};
    logic [31:0] st_data [4] = '{32'h1234BEEF, 32'h0000CAFE, 32'hFFFFFFA5, 32'h0000003C};
    logic [3:0]  st_strb [4] = '{4'b1100, 4'b0011, 4'b0010, 4'b1000};
    logic [31:0] st_lane [4] = '{32'hBEEFBEEF, 32'hCAFECAFE, 32'hA5A5A5A5, 32'h3C3C3C3C};

    logic [2:0]  ld_f3   [7] = '{FUNCT3_B, FUNCT3_BU, FUNCT3_H, FUNCT3_HU, FUNCT3_H, FUNCT3_W, FUNCT3_B};
    logic [31:0] ld_addr [7] = '{32'h13, 32'h13, 32'h16, 32'h16, 32'h14, 32'h18, 32'h10};
    logic [31:0] ld_word [7] = '{32'h80FF0000, 32'h80FF0000, 32'h80017FFF, 32'h80017FFF,
                                 32'h80017FFF, 32'hCAFEF00D, 32'h0000007F};
    logic [31:0] ld_exp  [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                 32'h00007FFF, 32'hCAFEF00D, 32'h0000007F};

    logic        bad_wr   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  bad_f3   [5] = '{FUNCT3_W, FUNCT3_H, FUNCT3_W, FUNCT3_H, FUNCT3_HU};
    logic [31:0] bad_addr [5] = '{32'h06, 32'h01, 32'h02, 32'h23, 32'h05};

    logic        ill_wr   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  ill_f3   [4] = '{3'b110, 3'b111, FUNCT3_BU, 3'b011};
    logic [31:0] ill_addr [4] = '{32'h03, 32'h08, 32'h01, 32'h0C};

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%b want 1", req_ready);
        end
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        acc_cyc    = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int start, n;
        start = rsp_cnt;
        n = 0;
        while (rsp_cnt == start && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_cnt == start) begin
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 60 cycles");
            lat = -1;
        end else begin
            lat = rsp_cyc - acc_cyc;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault, mem_addr, mem_wdata,
             mem_wstrb, mem_write, mem_read} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: ready=%b rsp_valid=%b rdata=%h addr=%h wdata=%h wstrb=%b wr=%b rd=%b",
                     req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_wstrb, mem_write, mem_read);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        int lat;
        issue(1'b1, FUNCT3_W, 32'h10, 32'd12);
        sb.push_back('{32'h0, 1'b0, 1'b0});
        @(negedge clk); #1;
        checks++;
        if ({mem_write, mem_read, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b0, 32'h10, 32'd12, 4'b1111}) begin
            errors++;
            $display("FAIL sw_bus: wr=%b rd=%b addr=%h wdata=%h wstrb=%b, want 1 0 00000010 0000000c 1111",
                     mem_write, mem_read, mem_addr, mem_wdata, mem_wstrb);
        end
        @(negedge clk); #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL sw_hold: mem_write=%b want 1 while awaiting ack", mem_write);
        end
        @(posedge clk); #1; mem_ack = 1'b1;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL sw_drop: mem_write=%b want 0 after ack", mem_write);
        end
        wait_rsp(lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL sw_latency: got %0d cycles want 5", lat);
        end
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_ready_return: req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic test_store_lanes();
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, st_f3[i], st_addr[i], st_data[i]);
            sb.push_back('{32'h0, 1'b0, 1'b0});
            mem_ack = 1'b1;
            @(negedge clk); #1;
            checks++;
            if ({mem_write, mem_addr, mem_wdata, mem_wstrb} !==
                {1'b1, st_addr[i] & 32'hFFFFFFFC, st_lane[i], st_strb[i]}) begin
                errors++;
                $display("FAIL store_lane[%0d]: wr=%b addr=%h wdata=%h wstrb=%b, want 1 %h %h %b",
                         i, mem_write, mem_addr, mem_wdata, mem_wstrb,
                         st_addr[i] & 32'hFFFFFFFC, st_lane[i], st_strb[i]);
            end
            @(posedge clk); #1; mem_ack = 1'b0;
            wait_rsp(lat);
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL store_latency[%0d]: got %0d want 3", i, lat);
            end
        end
    endtask

    task automatic test_loads();
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, ld_f3[i], ld_addr[i], 32'hFFFFFFFF);
            sb.push_back('{ld_exp[i], 1'b0, 1'b0});
            mem_rdata = ld_word[i];
            mem_ack   = 1'b1;
            @(negedge clk); #1;
            checks++;
            if ({mem_read, mem_write, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'b0000, ld_addr[i] & 32'hFFFFFFFC}) begin
                errors++;
                $display("FAIL load_bus[%0d]: rd=%b wr=%b wstrb=%b addr=%h", i, mem_read, mem_write, mem_wstrb, mem_addr);
            end
            @(posedge clk); #1; mem_ack = 1'b0; mem_rdata = 32'h0;
            wait_rsp(lat);
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL load_latency[%0d]: got %0d want 3", i, lat);
            end
        end
    endtask

    task automatic test_misaligned();
        logic seen, done;
        for (int i = 0; i < 5; i++) begin
            issue(bad_wr[i], bad_f3[i], bad_addr[i], 32'hFFFFFFFF);
            sb.push_back('{32'h0, 1'b1, 1'b0});
            seen = 1'b0;
            done = 1'b0;
            for (int k = 0; k < 10 && !done; k++) begin
                @(negedge clk); #1;
                if (mem_read || mem_write) seen = 1'b1;
                if (rsp_valid) done = 1'b1;
            end
            checks++;
            if (!done || seen || (rsp_cyc - acc_cyc) != 2) begin
                errors++;
                $display("FAIL misaligned[%0d]: rsp_seen=%b strobe_seen=%b latency=%0d, want 1 0 2",
                         i, done, seen, rsp_cyc - acc_cyc);
            end
        end
    endtask

    task automatic test_illegal();
        logic seen, done;
        for (int i = 0; i < 4; i++) begin
            issue(ill_wr[i], ill_f3[i], ill_addr[i], 32'h12345678);
            sb.push_back('{32'h0, 1'b0, 1'b1});
            seen = 1'b0;
            done = 1'b0;
            for (int k = 0; k < 10 && !done; k++) begin
                @(negedge clk); #1;
                if (mem_read || mem_write) seen = 1'b1;
                if (rsp_valid) done = 1'b1;
            end
            checks++;
            if (!done || seen || (rsp_cyc - acc_cyc) != 2) begin
                errors++;
                $display("FAIL illegal[%0d]: rsp_seen=%b strobe_seen=%b latency=%0d, want 1 0 2",
                         i, done, seen, rsp_cyc - acc_cyc);
            end
        end
    endtask

    task automatic test_timeout();
        int hi, lat;
        logic done;
        issue(1'b0, FUNCT3_H, 32'h40, 32'h0);
        sb.push_back('{32'h0, 1'b0, 1'b1});
        hi = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk); #1;
            if (mem_read) hi++;
            if (rsp_valid) done = 1'b1;
        end
        checks++;
        if (!done || hi != 16 || (rsp_cyc - acc_cyc) != 18) begin
            errors++;
            $display("FAIL timeout: rsp_seen=%b read_cycles=%0d latency=%0d, want 1 16 18",
                     done, hi, rsp_cyc - acc_cyc);
        end
        issue(1'b0, FUNCT3_W, 32'h44, 32'h0);
        sb.push_back('{32'h12345678, 1'b0, 1'b0});
        mem_rdata = 32'h12345678;
        mem_ack   = 1'b1;
        @(posedge clk); #1; mem_ack = 1'b0;
        wait_rsp(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL after_timeout_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_ack_at_limit();
        int lat;
        issue(1'b0, FUNCT3_W, 32'h30, 32'h0);
        sb.push_back('{32'h0BADCAFE, 1'b0, 1'b0});
        repeat (15) @(posedge clk);
        #1;
        mem_rdata = 32'h0BADCAFE;
        mem_ack   = 1'b1;
        @(posedge clk); #1; mem_ack = 1'b0;
        wait_rsp(lat);
        checks++;
        if (lat != 18) begin
            errors++;
            $display("FAIL ack_at_limit_latency: got %0d want 18", lat);
        end
    endtask

    task automatic test_reset_mid_access();
        int start, lat;
        issue(1'b1, FUNCT3_W, 32'h50, 32'hDEADBEEF);
        @(negedge clk); #1;
        start = rsp_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_write, mem_read, req_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_mid_access: wr=%b rd=%b ready=%b rsp_valid=%b, want 0 0 1 0",
                     mem_write, mem_read, req_ready, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_cnt != start) begin
            errors++;
            $display("FAIL reset_release: ready=%b responses=%0d, want 1 0", req_ready, rsp_cnt - start);
        end
        issue(1'b0, 3'b011, 32'h0, 32'h0);
        sb.push_back('{32'h0, 1'b0, 1'b1});
        wait_rsp(lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL illegal_load_latency: got %0d want 2", lat);
        end
    endtask

    task automatic test_back_to_back();
        int start, n;
        start = rsp_cnt;
        @(negedge clk);
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (rsp_cnt != start || req_ready !== 1'b1 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: responses=%0d ready=%b rd=%b, want 0 1 0",
                     rsp_cnt - start, req_ready, mem_read);
        end
        sb.push_back('{32'h000000AB, 1'b0, 1'b0});
        sb.push_back('{32'h0, 1'b0, 1'b0});
        @(negedge clk);
        req_write = 1'b0; req_funct3 = FUNCT3_BU; req_addr = 32'h11; req_wdata = 32'h0;
        req_valid = 1'b1;
        mem_rdata = 32'h0000AB00;
        @(posedge clk); #1;
        // Second request held on the bus while the first is still in flight.
        req_write = 1'b1; req_funct3 = FUNCT3_W; req_addr = 32'h60; req_wdata = 32'h5555AAAA;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = 32'hFFFFFFFF;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({mem_write, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h60, 32'h5555AAAA, 4'b1111}) begin
            errors++;
            $display("FAIL b2b_second_bus: wr=%b addr=%h wdata=%h wstrb=%b, want 1 00000060 5555aaaa 1111",
                     mem_write, mem_addr, mem_wdata, mem_wstrb);
        end
        @(posedge clk); #1; mem_ack = 1'b0;
        n = 0;
        while (rsp_cnt < start + 2 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (rsp_cnt != start + 2) begin
            errors++;
            $display("FAIL b2b_responses: got %0d want 2", rsp_cnt - start);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_store_lanes();
        test_misaligned();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_access();
        test_illegal();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected responses never arrived, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
